// File: rtl/avf_dur_sched.sv
// avf_dur_sched: round-robin drain scheduler for AVF duration trackers.
// Owns the window timestamp, grants one tracker pop per cycle and folds the
// popped duration into that source's residency accumulator through one
// shared adder. A run/stop/drain FSM sequences the measurement window.
// Optional build macro AVF_DUR_SAT_EN: saturating accumulators plus a
// sticky sat_flag output (bit i = acc[i], bit NUM_SRC = sample_cnt).
module avf_dur_sched #(
    parameter int NUM_SRC = 4,
    parameter int DUR_W   = 10,
    parameter int ACC_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       clear,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*DUR_W-1:0]   src_dur,
    output logic [NUM_SRC-1:0]         src_pop,
    output logic [DUR_W-1:0]           timestamp,
    output logic [NUM_SRC*ACC_W-1:0]   acc,
    output logic [ACC_W-1:0]           sample_cnt,
    output logic                       busy,
    output logic                       done
`ifdef AVF_DUR_SAT_EN
    ,
    output logic [NUM_SRC:0]           sat_flag
`endif
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [DUR_W-1:0]   r_ts;
    logic [ACC_W-1:0]   r_acc [NUM_SRC];
    logic [ACC_W-1:0]   r_cnt;
    logic [PTR_W-1:0]   r_rr_ptr;

    logic               w_idle_like;
    logic               w_arb_en;
    logic               w_go;
    logic               w_clr;
    logic               w_any;
    logic               w_pop;
    logic [PTR_W-1:0]   w_grant;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [DUR_W-1:0]   w_sel_dur;
    logic [ACC_W-1:0]   w_sel_acc;
    logic [ACC_W-1:0]   w_acc_new;
    logic [ACC_W-1:0]   w_cnt_new;
    logic               w_drain_exit;

`ifdef AVF_DUR_SAT_EN
    localparam int SUM_W = ((ACC_W > DUR_W) ? ACC_W : DUR_W) + 1;
    logic [SUM_W-1:0]   w_sum;
    logic               w_acc_ovf;
    logic               w_cnt_ovf;
    logic [NUM_SRC:0]   r_sat;
`endif

    // State-derived qualifiers shared by the FSM, arbiter and datapath.
    always_comb begin
        w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_DONE);
        w_arb_en     = (r_state == ST_RUN)  || (r_state == ST_DRAIN);
        w_go         = w_idle_like && start;
        w_clr        = w_idle_like && clear;
        w_drain_exit = (r_state == ST_DRAIN) && (src_valid == {NUM_SRC{1'b0}});
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: start from IDLE/DONE, stop from RUN, drain until empty.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_exit) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Round-robin search: first valid source at or after rr_ptr, with wrap.
    always_comb begin
        int v_idx;
        v_idx   = 0;
        w_any   = 1'b0;
        w_grant = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_SRC) begin
                v_idx = v_idx - NUM_SRC;
            end else begin
                v_idx = v_idx;
            end
            if (!w_any && src_valid[v_idx]) begin
                w_any   = 1'b1;
                w_grant = PTR_W'(v_idx);
            end else begin
                w_any   = w_any;
            end
        end
    end

    // Pop qualification, one-hot pop vector and pointer advance.
    always_comb begin
        w_pop = w_arb_en && w_any;
        if (w_pop) begin
            src_pop = {{(NUM_SRC-1){1'b0}}, 1'b1} << w_grant;
        end else begin
            src_pop = {NUM_SRC{1'b0}};
        end
        if (w_grant == PTR_W'(NUM_SRC - 1)) begin
            w_ptr_nxt = {PTR_W{1'b0}};
        end else begin
            w_ptr_nxt = w_grant + PTR_W'(1);
        end
    end

    // Shared accumulate adder fed by the granted source, plus sample counter.
    always_comb begin
        w_sel_dur = src_dur[int'(w_grant)*DUR_W +: DUR_W];
        w_sel_acc = r_acc[w_grant];
`ifdef AVF_DUR_SAT_EN
        w_sum     = SUM_W'(w_sel_acc) + SUM_W'(w_sel_dur);
        w_acc_ovf = |w_sum[SUM_W-1:ACC_W];
        w_cnt_ovf = &r_cnt;
        if (w_acc_ovf) begin
            w_acc_new = {ACC_W{1'b1}};
        end else begin
            w_acc_new = w_sum[ACC_W-1:0];
        end
        if (w_cnt_ovf) begin
            w_cnt_new = r_cnt;
        end else begin
            w_cnt_new = r_cnt + ACC_W'(1);
        end
`else
        w_acc_new = w_sel_acc + ACC_W'(w_sel_dur);
        w_cnt_new = r_cnt + ACC_W'(1);
`endif
    end

    // Window timestamp: zeroed on window start, counts in RUN/DRAIN, else frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ts <= {DUR_W{1'b0}};
        end else if (w_go) begin
            r_ts <= {DUR_W{1'b0}};
        end else if (w_arb_en) begin
            r_ts <= r_ts + DUR_W'(1);
        end else begin
            r_ts <= r_ts;
        end
    end

    // Round-robin pointer moves past the source just served.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= {PTR_W{1'b0}};
        end else if (w_pop) begin
            r_rr_ptr <= w_ptr_nxt;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // Per-source accumulators and sample count: clear, or fold in the pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_acc[i] <= {ACC_W{1'b0}};
            end
            r_cnt <= {ACC_W{1'b0}};
        end else if (w_clr) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_acc[i] <= {ACC_W{1'b0}};
            end
            r_cnt <= {ACC_W{1'b0}};
        end else if (w_pop) begin
            r_acc[w_grant] <= w_acc_new;
            r_cnt          <= w_cnt_new;
        end else begin
            r_cnt <= r_cnt;
        end
    end

`ifdef AVF_DUR_SAT_EN
    // Sticky saturation flags, dropped only by clear or reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sat <= {(NUM_SRC+1){1'b0}};
        end else if (w_clr) begin
            r_sat <= {(NUM_SRC+1){1'b0}};
        end else if (w_pop) begin
            r_sat[w_grant] <= r_sat[w_grant] | w_acc_ovf;
            r_sat[NUM_SRC] <= r_sat[NUM_SRC] | w_cnt_ovf;
        end else begin
            r_sat <= r_sat;
        end
    end

    assign sat_flag = r_sat;
`endif

    // Flatten the accumulator array onto the output bus.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_acc_out
            assign acc[gi*ACC_W +: ACC_W] = r_acc[gi];
        end
    endgenerate

    assign timestamp  = r_ts;
    assign sample_cnt = r_cnt;
    assign busy       = w_arb_en;
    assign done       = w_drain_exit;

endmodule

// File: doc/avf_dur_sched.md
Name: avf_dur_sched

Overview:
- Round-robin drain scheduler for NUM_SRC duration-tracker queues (instruction buffer, issue queue, ROB, ...).
- Owns the free-running timestamp that the trackers stamp residency with.
- Grants one tracker per cycle, issues its pop, and adds the popped duration into that source's AVF residency accumulator through a single shared adder.
- A run/stop/drain state machine sequences a measurement window.

Parameters:
NUM_SRC, 4, number of duration trackers served (2..8)
DUR_W, 10, duration/timestamp width (14-bit cycle count with 4 LSBs dropped)
ACC_W, 32, per-source accumulator width

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
start  input  1  pulse; begin a measurement window (honoured only in IDLE or DONE)
stop  input  1  pulse; end the window and drain (honoured only in RUN)
clear  input  1  pulse; zero all accumulators and sample_cnt (honoured only in IDLE or DONE)
src_valid  input  NUM_SRC  tracker i has a completed duration at its head
src_dur  input  NUM_SRC*DUR_W  head duration of tracker i; slice i = bits [i*DUR_W +: DUR_W]
src_pop  output  NUM_SRC  one-hot pop to the granted tracker
timestamp  output  DUR_W  free-running window time
acc  output  NUM_SRC*ACC_W  per-source accumulated duration
sample_cnt  output  ACC_W  total durations accumulated
busy  output  1  state is RUN or DRAIN
done  output  1  single-cycle pulse on DRAIN->DONE

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; timestamp=0, acc=0, sample_cnt=0.
  - src_pop=0, busy=0, done=0; rr_ptr=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE --start--> RUN. On entry, timestamp is loaded with 0; acc is untouched.
  - RUN --stop--> DRAIN.
  - DRAIN --(src_valid==0 in a cycle with no pop)--> DONE; done=1 for that one cycle.
  - start+clear in the same cycle in IDLE/DONE: clear applies, then RUN starts.
  - start in RUN/DRAIN is ignored. stop outside RUN is ignored.
- Timestamp:
  - Increments by 1 every cycle in RUN and DRAIN.
  - Wraps at 2^DUR_W.
  - Frozen in IDLE and DONE.
- Arbitration (RUN and DRAIN only):
  - Combinational grant = first i with src_valid[i]=1, searching from rr_ptr upward with wrap.
  - src_pop = onehot(grant) in the same cycle; src_pop=0 if no source is valid.
  - At most one pop per cycle.
  - When a pop occurs: rr_ptr <= grant+1 (mod NUM_SRC).
- Accumulation, 1-cycle latency:
  - At the clock edge where src_pop[i]=1: acc[i] <= acc[i] + zero-extended src_dur[i], and sample_cnt <= sample_cnt+1.
  - The updated value is visible the following cycle.
- Tracker contract: after a pop, src_valid/src_dur must reflect the new head by the next cycle. Back-to-back pops to the same source are therefore legal when it is the only requester.
- Fairness: with all sources continuously valid, the grant order is 0,1,..,NUM_SRC-1,0,...
- Overflow: without the optional feature, acc and sample_cnt wrap modulo 2^ACC_W.
- Reset mid-operation: all state returns to the reset values immediately. Tracker contents are the trackers' own concern.
- In IDLE and DONE, src_valid is ignored (no pops), so entries stay queued.

Optional Feature:
- Macro: AVF_DUR_SAT_EN.
- Defined:
  - Each acc[i] and sample_cnt saturates at 2^ACC_W-1 instead of wrapping.
  - Adds output sat_flag (NUM_SRC+1 bits): bit i = acc[i] saturated, bit NUM_SRC = sample_cnt saturated.
  - sat_flag is sticky until clear or reset.
- Undefined: modulo arithmetic, and no sat_flag port.

Test Plan:
- Reset, then start. timestamp reads 0,1,2,... each cycle. Hold 1023 cycles -> timestamp wraps to 0 on the next cycle. busy=1.
- All 4 src_valid=1 for 8 cycles in RUN, src_dur[i]=i+1 -> pops one-hot in order 0,1,2,3,0,1,2,3 -> acc={2,4,6,8}, sample_cnt=8.
- Only src 2 valid for 3 cycles with dur=100 -> src_pop=0100 on 3 consecutive cycles -> acc[2]=300, sample_cnt=3.
- stop while src1 and src3 are valid, queues drain after 2 and 1 pops -> state DRAIN; 3 pops complete; done pulses exactly once, 1 cycle after the last pop; further src_valid is ignored (no pops).
- In DONE, pulse clear and start together -> acc=0, sample_cnt=0, timestamp=0, state RUN. start during RUN -> no effect. reset_n low mid-RUN -> outputs at reset values asynchronously.
- AVF_DUR_SAT_EN with ACC_W=8: accumulate src 0 dur=200 twice -> acc[0]=255 and sat_flag[0]=1. Without the macro -> acc[0]=144.
